call_announcer: RTL and testbench
=================================

// Module: call_announcer
// PURPOSE
//   Downstream of response_system_top. Takes each counter-call event (counter A-E
//   plus service number), queues it and announces it on a 4-digit multiplexed
//   7-segment display. Each call blinks for a fixed hold time, then stays on
//   steady until the next call. A burst of calls is shown in arrival order.
// PARAMETERS
//   FIFO_DEPTH   4   call events buffered; power of 2, >=2
//   HOLD_CYCLES  40  clocks each call stays in ANNOUNCE (blinking)
//   BLINK_CYCLES 5   clocks per blink half-period; ON half first
//   SCAN_CYCLES  2   clocks per digit before the scan moves on
// PORTS
//   clk          in   1   system clock, rising edge
//   rst          in   1   synchronous reset, active-low
//   call_valid   in   1   one-cycle pulse: a counter has called a number
//   call_counter in   3   0..4 = A..E; 5..7 are invalid
//   call_number  in   6   service number being called (0..63)
//   seg          out  7   {g,f,e,d,c,b,a}, active-high
//   an           out  4   one-hot digit enable, active-high; an[3] = leftmost
//   busy         out  1   1 while in ANNOUNCE
//   pending      out  $clog2(FIFO_DEPTH+1)  entries waiting in FIFO
//   overflow     out  1   sticky; set when a valid call is dropped; cleared by reset
// BEHAVIOUR
//   One clock. Synchronous active-low reset: rst sampled low at a rising edge
//   clears all state, including mid-announce. Reset values: FIFO empty,
//   pending=0, busy=0, overflow=0, state=IDLE, scan index=0, an=4'b0001,
//   display content = dashes, so seg=7'b1000000.
//   Push: at an edge with call_valid=1 and call_counter<=4.
//     - Written if count<FIFO_DEPTH, or if a pop happens in the same cycle.
//     - Otherwise dropped and overflow<=1.
//     - call_counter>=5 is ignored silently; no push, no overflow.
//   FSM (2 states):
//     IDLE: shows the last call steady (dashes after reset). If FIFO non-empty:
//       pop the head, load it into the display registers, clear hold/blink
//       counters, go ANNOUNCE. Popped call is on the outputs from the next edge.
//     ANNOUNCE: busy=1. Runs exactly HOLD_CYCLES clocks, then returns to IDLE.
//       Leaves ANNOUNCE even if FIFO non-empty. Next pop happens in IDLE the
//       following cycle, so there is 1 steady IDLE cycle between calls.
//   Latency: call accepted into empty FIFO at edge k -> popped at edge k+1
//     -> busy=1 and new content shown after edge k+1.
//   Blink: phase counter counts 0..2*BLINK_CYCLES-1 and wraps; restarts at 0 on
//     entry to ANNOUNCE. First BLINK_CYCLES clocks ON, next BLINK_CYCLES OFF.
//     OFF forces an=0. The scan keeps running while OFF. IDLE is always ON.
//   Scan: index 0->1->2->3->0, advancing every SCAN_CYCLES clocks,
//     free-running from reset. an = 1<<index.
//   Digit content:
//     - d3 = counter letter: A=1110111 b=1111100 C=0111001 d=1011110 E=1111001
//     - d2 = blank (0000000)
//     - d1 = number/10; d1 blank when number<10 (no leading zero)
//     - d0 = number%10
//     - digits 0-9 use the standard segment table
//     - dash state: all four digits show 1000000
//   pending = FIFO count; a simultaneous push and pop leaves it unchanged.
//   All outputs are registered or decoded from registers; no input->output comb path.
// TESTING
//   T1 reset mid-ANNOUNCE: rst low 1 clk -> busy=0, pending=0, overflow=0, seg=1000000 on all digits.
//   T2 single call C/7 in IDLE: busy=1 one edge after accept; d3=0111001, d1 blank, d0=0000111;
//      an=0 on clocks 5-9 of announce; busy=0 after 40 clocks, then steady display.
//   T3 call E/42: d1=1100110, d0=1011011; blink period 10 clocks; an cycles 0001->0010->0100->1000 every 2 clocks.
//   T4 burst of 6 calls on consecutive clocks (A/1..A/6, depth 4): first popped, next 4 queued, 6th dropped
//      -> overflow=1, pending peaks at 4; announced order 1,2,3,4,5; 1 IDLE clock between each.
//   T5 push while full in the same cycle as a pop: push accepted, pending unchanged, overflow stays 0.
//   T6 call_counter=6 pulse: no push, pending unchanged, overflow=0, display unchanged.

Source files
------------

// File: rtl/call_announcer.sv
// Small FIFO for call events; a write is taken when full if a read happens on the same edge.
// Latency: written entry visible at head one edge after the write.
// Backpressure: wrRdy drops only when full and no read is under way.
module call_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wrVld,
    input  logic [WIDTH-1:0]           wrDat,
    output logic                       wrRdy,
    input  logic                       rdEn,
    output logic [WIDTH-1:0]           rdDat,
    output logic                       rdVld,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic             doWr, doRd;

    assign rdVld = (count != '0);
    assign doRd  = rdEn && rdVld;
    assign wrRdy = (count < CNT_W'(DEPTH)) || doRd;
    assign doWr  = wrVld && wrRdy;
    assign rdDat = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doWr) begin
            mem[wrPtr] <= wrDat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doWr) wrPtr <= wrPtr + 1'b1;
            if (doRd) rdPtr <= rdPtr + 1'b1;
            case ({doWr, doRd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Queues counter-call events and announces each on a 4-digit multiplexed 7-segment display.
// Latency: call into an empty queue at edge k is shown (blinking, busy=1) after edge k+1.
// Backpressure: none upstream; a call arriving with the queue full and no pop is dropped, setting overflow.
module call_announcer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int HOLD_CYCLES  = 40,
    parameter int BLINK_CYCLES = 5,
    parameter int SCAN_CYCLES  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            call_valid,
    input  logic [2:0]                      call_counter,
    input  logic [5:0]                      call_number,
    output logic [6:0]                      seg,
    output logic [3:0]                      an,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] pending,
    output logic                            overflow
);
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BLINK_W = $clog2(2 * BLINK_CYCLES);
    localparam int SCAN_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    typedef struct packed {
        logic [2:0] counter;
        logic [5:0] number;
    } callT;

    typedef enum logic {IDLE, ANNOUNCE} stateT;

    stateT               state, nextState;
    callT                fifoHead, dispCall;
    logic                fifoRdVld, fifoWrRdy, pop, callOk, dispShow, blinkOn;
    logic [HOLD_W-1:0]   holdCnt;
    logic [BLINK_W-1:0]  blinkCnt;
    logic [SCAN_W-1:0]   scanCnt;
    logic [1:0]          scanIdx;
    logic [5:0]          tens, ones;

    function automatic logic [6:0] digitSeg(input logic [5:0] d);
        case (d)
            6'd0:    digitSeg = 7'b0111111;
            6'd1:    digitSeg = 7'b0000110;
            6'd2:    digitSeg = 7'b1011011;
            6'd3:    digitSeg = 7'b1001111;
            6'd4:    digitSeg = 7'b1100110;
            6'd5:    digitSeg = 7'b1101101;
            6'd6:    digitSeg = 7'b1111101;
            6'd7:    digitSeg = 7'b0000111;
            6'd8:    digitSeg = 7'b1111111;
            6'd9:    digitSeg = 7'b1101111;
            default: digitSeg = 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] letterSeg(input logic [2:0] c);
        case (c)
            3'd0:    letterSeg = 7'b1110111;
            3'd1:    letterSeg = 7'b1111100;
            3'd2:    letterSeg = 7'b0111001;
            3'd3:    letterSeg = 7'b1011110;
            3'd4:    letterSeg = 7'b1111001;
            default: letterSeg = 7'b0000000;
        endcase
    endfunction

    // Counter codes 5..7 never reach the queue and never count as drops.
    assign callOk = call_valid && (call_counter <= 3'd4);

    call_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(callT))) fifoInst (
        .clk   (clk),
        .rst   (rst),
        .wrVld (callOk),
        .wrDat ({call_counter, call_number}),
        .wrRdy (fifoWrRdy),
        .rdEn  (pop),
        .rdDat (fifoHead),
        .rdVld (fifoRdVld),
        .count (pending)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (fifoRdVld) begin
                    pop       = 1'b1;
                    nextState = ANNOUNCE;
                end
            end
            ANNOUNCE: begin
                if (holdCnt == HOLD_W'(HOLD_CYCLES - 1)) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            holdCnt  <= '0;
            blinkCnt <= '0;
            dispShow <= 1'b0;
            dispCall <= '0;
            overflow <= 1'b0;
        end else begin
            if (callOk && !fifoWrRdy) overflow <= 1'b1;
            if (pop) begin
                dispCall <= fifoHead;
                dispShow <= 1'b1;
                holdCnt  <= '0;
                blinkCnt <= '0;
            end else if (state == ANNOUNCE) begin
                holdCnt  <= holdCnt + 1'b1;
                blinkCnt <= (blinkCnt == BLINK_W'(2 * BLINK_CYCLES - 1)) ? '0 : blinkCnt + 1'b1;
            end
        end
    end

    // Digit scan free-runs from reset, independent of the FSM and blink phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scanCnt <= '0;
            scanIdx <= 2'd0;
        end else if (scanCnt == SCAN_W'(SCAN_CYCLES - 1)) begin
            scanCnt <= '0;
            scanIdx <= scanIdx + 2'd1;
        end else begin
            scanCnt <= scanCnt + 1'b1;
        end
    end

    assign busy    = (state == ANNOUNCE);
    assign blinkOn = (state == IDLE) || (blinkCnt < BLINK_W'(BLINK_CYCLES));
    assign an      = blinkOn ? (4'b0001 << scanIdx) : 4'b0000;

    always_comb begin
        tens = dispCall.number / 6'd10;
        ones = dispCall.number % 6'd10;
        seg  = SEG_DASH;
        if (dispShow) begin
            case (scanIdx)
                2'd3:    seg = letterSeg(dispCall.counter);
                2'd2:    seg = 7'b0000000;
                2'd1:    seg = (tens == 6'd0) ? 7'b0000000 : digitSeg(tens);
                default: seg = digitSeg(ones);
            endcase
        end
    end
endmodule

// File: tb/tb_call_announcer.sv
// Bench for call_announcer: queue/time-based reference model compared every cycle plus directed literal checks.
module tb_call_announcer;
    localparam int DEPTH = 4;
    localparam int HOLD  = 40;
    localparam int BLINK = 5;
    localparam int SCAN  = 2;

    localparam logic [6:0] DIG [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    localparam logic [6:0] LET [5]  = '{7'b1110111, 7'b1111100, 7'b0111001, 7'b1011110, 7'b1111001};

    typedef struct packed {
        logic [2:0] ctr;
        logic [5:0] num;
    } callT;

    logic       clk;
    logic       rst;
    logic       call_valid;
    logic [2:0] call_counter;
    logic [5:0] call_number;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    call_announcer #(
        .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK), .SCAN_CYCLES(SCAN)
    ) dut (
        .clk(clk), .rst(rst), .call_valid(call_valid), .call_counter(call_counter),
        .call_number(call_number), .seg(seg), .an(an), .busy(busy), .pending(pending),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got 'h%0h expected 'h%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: queue of waiting calls, current call, age within the announce.
    callT mq[$];
    callT mCur;
    bit   mValid = 0;
    bit   mShow, mAnn, mOver;
    int   mAge, mScan;

    function automatic logic [6:0] modelDigit(input int idx, input callT c);
        case (idx)
            3:       return LET[c.ctr];
            2:       return 7'b0000000;
            1:       return (c.num < 10) ? 7'b0000000 : DIG[c.num / 10];
            default: return DIG[c.num % 10];
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            mShow  = 0;
            mAnn   = 0;
            mOver  = 0;
            mAge   = 0;
            mScan  = 0;
            mValid = 1;
        end else begin
            bit popNow;
            int sizeBefore;
            sizeBefore = mq.size();
            popNow     = !mAnn && (sizeBefore > 0);
            mScan++;
            if (mAnn) begin
                mAge++;
                if (mAge == HOLD) mAnn = 0;
            end
            if (popNow) begin
                mCur  = mq.pop_front();
                mShow = 1;
                mAnn  = 1;
                mAge  = 0;
            end
            if (call_valid && call_counter <= 4) begin
                if (sizeBefore < DEPTH || popNow) mq.push_back(callT'{ctr: call_counter, num: call_number});
                else mOver = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mValid) begin
            int         idx;
            bit         on;
            logic [3:0] eAn;
            logic [6:0] eSeg;
            idx  = (mScan / SCAN) % 4;
            on   = !mAnn || ((mAge % (2 * BLINK)) < BLINK);
            eAn  = on ? (4'b0001 << idx) : 4'b0000;
            eSeg = mShow ? modelDigit(idx, mCur) : 7'b1000000;
            checkVal("cyc_seg", seg, eSeg);
            checkVal("cyc_an", an, eAn);
            checkVal("cyc_busy", busy, mAnn);
            checkVal("cyc_pending", pending, mq.size());
            checkVal("cyc_overflow", overflow, mOver);
        end
    end

    task automatic sendCall(input logic [2:0] c, input logic [5:0] n);
        call_valid   = 1'b1;
        call_counter = c;
        call_number  = n;
        @(posedge clk);
        #1;
        call_valid = 1'b0;
    endtask

    // Checks one full announce started from an empty queue, with literal digit patterns.
    task automatic announceCheck(input string tag, input logic [6:0] eL, input logic [6:0] eT,
                                 input logic [6:0] eO);
        logic [3:0] prevAn;
        @(negedge clk);
        checkVal({tag, "_pend_accept"}, pending, 1);
        checkVal({tag, "_busy_accept"}, busy, 0);
        prevAn = 4'b0000;
        for (int age = 0; age < HOLD; age++) begin
            @(negedge clk);
            checkVal({tag, "_busy"}, busy, 1);
            checkVal({tag, "_blink_off"}, (an == 4'b0000), ((age % 10) >= 5));
            if (an == 4'b1000) checkVal({tag, "_d3"}, seg, eL);
            if (an == 4'b0100) checkVal({tag, "_d2"}, seg, 7'b0000000);
            if (an == 4'b0010) checkVal({tag, "_d1"}, seg, eT);
            if (an == 4'b0001) checkVal({tag, "_d0"}, seg, eO);
            if (an != 4'b0000 && prevAn != 4'b0000 && an != prevAn)
                checkVal({tag, "_scan_rot"}, an, {prevAn[2:0], prevAn[3]});
            prevAn = an;
        end
        @(negedge clk);
        checkVal({tag, "_busy_end"}, busy, 0);
        checkVal({tag, "_idle_on"}, (an != 4'b0000), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst          = 1'b0;
        call_valid   = 1'b0;
        call_counter = 3'd0;
        call_number  = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkVal("rst_seg", seg, 7'b1000000);
        checkVal("rst_an", an, 4'b0001);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_pending", pending, 0);
        checkVal("rst_overflow", overflow, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // T2: C/7, single digit number, no leading zero
        sendCall(3'd2, 6'd7);
        announceCheck("T2", 7'b0111001, 7'b0000000, 7'b0000111);

        // T3: E/42
        sendCall(3'd4, 6'd42);
        announceCheck("T3", 7'b1111001, 7'b1100110, 7'b1011011);

        // T4: burst A/1..A/6 on consecutive clocks
        for (int i = 1; i <= 6; i++) begin
            call_valid   = 1'b1;
            call_counter = 3'd0;
            call_number  = 6'(i);
            @(posedge clk);
            #1;
        end
        call_valid = 1'b0;
        @(negedge clk);
        checkVal("T4_pend_peak", pending, 4);
        checkVal("T4_overflow", overflow, 1);
        for (int n = 1; n <= 5; n++) begin
            int         hi;
            bit         seen;
            logic [6:0] got;
            hi   = 0;
            seen = 0;
            got  = 7'b0000000;
            while (busy && hi < 100) begin
                if (an == 4'b0001) begin
                    got  = seg;
                    seen = 1;
                end
                hi++;
                @(negedge clk);
            end
            checkVal("T4_order_seen", seen, 1);
            checkVal("T4_order", got, DIG[n]);
            checkVal("T4_hold_len", hi, (n == 1) ? 36 : 40);
            @(negedge clk);
            checkVal("T4_gap", busy, (n < 5) ? 1 : 0);
        end
        checkVal("T4_drained", pending, 0);

        // T1: reset in the middle of an announce
        sendCall(3'd1, 6'd9);
        repeat (5) @(negedge clk);
        checkVal("T1_pre_busy", busy, 1);
        checkVal("T1_pre_ovf", overflow, 1);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkVal("T1_busy", busy, 0);
        checkVal("T1_pending", pending, 0);
        checkVal("T1_overflow", overflow, 0);
        checkVal("T1_an", an, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            checkVal("T1_dash", seg, 7'b1000000);
            @(negedge clk);
        end

        // T5: fill the queue, then push on the same edge as the IDLE pop
        for (int i = 0; i < 5; i++) begin
            call_valid   = 1'b1;
            call_counter = 3'd1;
            call_number  = 6'(10 + i);
            @(posedge clk);
            #1;
        end
        call_valid = 1'b0;
        @(negedge clk);
        checkVal("T5_full", pending, 4);
        g = 0;
        while (busy && g < 60) begin
            @(negedge clk);
            g++;
        end
        checkVal("T5_idle", busy, 0);
        call_valid   = 1'b1;
        call_counter = 3'd3;
        call_number  = 6'd63;
        @(posedge clk);
        #1 call_valid = 1'b0;
        @(negedge clk);
        checkVal("T5_pend_same", pending, 4);
        checkVal("T5_ovf", overflow, 0);
        checkVal("T5_busy", busy, 1);

        // T6: invalid counter code is ignored
        call_valid   = 1'b1;
        call_counter = 3'd6;
        call_number  = 6'd5;
        @(posedge clk);
        #1 call_valid = 1'b0;
        @(negedge clk);
        checkVal("T6_pend", pending, 4);
        checkVal("T6_ovf", overflow, 0);

        g = 0;
        while ((pending != 0 || busy) && g < 400) begin
            @(negedge clk);
            g++;
        end
        checkVal("drain_empty", (pending == 0 && !busy), 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (an == 4'b1000) checkVal("final_d3", seg, 7'b1011110);
            if (an == 4'b0100) checkVal("final_d2", seg, 7'b0000000);
            if (an == 4'b0010) checkVal("final_d1", seg, 7'b1111101);
            if (an == 4'b0001) checkVal("final_d0", seg, 7'b1001111);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
